// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the iterative divider controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITER   = DIV_DATA_W;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring iteration: shift, trial subtract, select quotient bit.
module div_ctrl_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]  work,
  input  logic [DATA_W-1:0]  divisor,
  output logic [2*DATA_W:0]  work_nxt
);

  logic [2*DATA_W:0] sh;
  logic [DATA_W:0]   diff;

  // The upper half stays below the divisor, so after the shift it fits in
  // DATA_W+1 bits and the difference sign bit is a valid borrow.
  always_comb begin
    sh   = work << 1;
    diff = sh[2*DATA_W:DATA_W] - {1'b0, divisor};
    if (!diff[DATA_W]) work_nxt = {diff, sh[DATA_W-1:1], 1'b1};
    else               work_nxt = sh;
  end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU multi-cycle controller: FSM, iteration counter, sign fix and
// registered {remainder, quotient} result with pipeline stall request.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                annul,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                stall_req
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  div_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*DATA_W:0] work, work_nxt;
  logic [DATA_W-1:0] dvsr;
  logic              sgn1, sgn2, sdiv;
  logic [DATA_W-1:0] quo, rem;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic c);
    return c ? -v : v;
  endfunction

  div_ctrl_step #(.DATA_W(DATA_W)) u_step (
    .work     (work),
    .divisor  (dvsr),
    .work_nxt (work_nxt)
  );

  assign quo = neg_if(work[DATA_W-1:0], sdiv & (sgn1 ^ sgn2));
  assign rem = neg_if(work[2*DATA_W-1:DATA_W], sdiv & sgn1);

  // Low in END so the stage advances on the same cycle ready is seen.
  assign stall_req = start & ~annul & (state != DIV_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      work   <= '0;
      dvsr   <= '0;
      sgn1   <= 1'b0;
      sgn2   <= 1'b0;
      sdiv   <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          ready  <= 1'b0;
          result <= '0;
          if (start && !annul) begin
            if (opdata2 == '0) begin
              state <= DIV_ZERO;
            end else begin
              state <= DIV_ON;
              cnt   <= '0;
              work  <= {{(DATA_W+1){1'b0}}, neg_if(opdata1, signed_div & opdata1[DATA_W-1])};
              dvsr  <= neg_if(opdata2, signed_div & opdata2[DATA_W-1]);
              sgn1  <= opdata1[DATA_W-1];
              sgn2  <= opdata2[DATA_W-1];
              sdiv  <= signed_div;
            end
          end
        end
        DIV_ZERO: begin
          result <= '0;
          if (annul) begin
            state <= DIV_IDLE;
            ready <= 1'b0;
          end else begin
            state <= DIV_END;
            ready <= 1'b1;
          end
        end
        DIV_ON: begin
          if (annul) begin
            state  <= DIV_IDLE;
            ready  <= 1'b0;
            result <= '0;
          end else if (cnt != LAST) begin
            work <= work_nxt;
            cnt  <= cnt + 1'b1;
          end else begin
            state  <= DIV_END;
            ready  <= 1'b1;
            result <= {rem, quo};
          end
        end
        DIV_END: begin
          if (annul || !start) begin
            state  <= DIV_IDLE;
            ready  <= 1'b0;
            result <= '0;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: latency, signed/unsigned results, annul, reset.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_div, annul;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready, stall_req;

  int vecs = 0;
  int errs = 0;
  logic [63:0] exp_q[$];

  div_ctrl #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drives one request starting now (just after an edge) and waits for ready.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit scramble, output int lat, output logic [63:0] res);
    start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
    exp_q.push_back(model(a, b, s));
    lat = -1;
    res = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (scramble && n == 3) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = ~s;
      end
      if (ready) begin
        lat = n; res = result; break;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    #1;
    vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", ready); end
    vecs++; if (result !== 64'd0) begin errs++; $display("FAIL reset_result: got %h want 0", result); end
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL reset_stall_idle: got %b want 0", stall_req); end
    start = 1'b1; #1;
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL reset_stall_start: got %b want 1", stall_req); end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL post_reset_ready: got %b want 0", ready); end
  endtask

  task automatic test_divu_basic;
    logic [63:0] exp;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    exp_q.push_back(model(32'd100, 32'd7, 1'b0));
    #1;
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL basic_stall_e0: got %b want 1", stall_req); end
    for (int n = 1; n <= 34; n++) begin
      @(posedge clk); #1;
      if (n == 33) begin
        vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL basic_ready_e33: got %b want 0", ready); end
        vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL basic_stall_e33: got %b want 1", stall_req); end
      end
    end
    exp = exp_q.pop_front();
    vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL basic_ready_e34: got %b want 1", ready); end
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL basic_stall_e34: got %b want 0", stall_req); end
    vecs++; if (result !== exp) begin errs++; $display("FAIL basic_result: got %h want %h", result, exp); end
    vecs++; if (result !== 64'h0000_0002_0000_000E) begin errs++; $display("FAIL basic_const: got %h want 000000020000000e", result); end
    start = 1'b0;
    @(posedge clk); #1;
    vecs++; if (ready !== 1'b0 || result !== 64'd0) begin
      errs++; $display("FAIL end_to_idle: got ready=%b result=%h want 0/0", ready, result);
    end
  endtask

  task automatic test_signed;
    logic [31:0] ta[5] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF9C};
    logic [31:0] tb[5] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd7};
    logic        ts[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] tc[5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_FFFF_FFFD,
                           64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                           64'hFFFF_FFFE_FFFF_FFF2};
    int lat;
    logic [63:0] res, exp;
    for (int i = 0; i < 5; i++) begin
      do_div(ta[i], tb[i], ts[i], 1'b0, lat, res);
      exp = exp_q.pop_front();
      vecs++; if (lat != 34) begin errs++; $display("FAIL signed_lat[%0d]: got %0d want 34", i, lat); end
      vecs++; if (res !== exp) begin errs++; $display("FAIL signed_res[%0d]: got %h want %h", i, res, exp); end
      vecs++; if (res !== tc[i]) begin errs++; $display("FAIL signed_const[%0d]: got %h want %h", i, res, tc[i]); end
    end
  endtask

  task automatic test_divzero;
    int lat;
    logic [63:0] res, exp;
    do_div(32'd5, 32'd0, 1'b0, 1'b0, lat, res);
    exp = exp_q.pop_front();
    vecs++; if (lat != 2) begin errs++; $display("FAIL divzero_lat: got %0d want 2", lat); end
    vecs++; if (res !== exp) begin errs++; $display("FAIL divzero_res: got %h want %h", res, exp); end
  endtask

  task automatic test_annul;
    int lat;
    bit seen;
    logic [63:0] res, exp;
    // Abort mid-operation.
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    #1;
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL annul_stall: got %b want 0", stall_req); end
    @(posedge clk); #1;
    vecs++; if (ready !== 1'b0 || result !== 64'd0) begin
      errs++; $display("FAIL annul_e11: got ready=%b result=%h want 0/0", ready, result);
    end
    start = 1'b0; annul = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    vecs++; if (seen) begin errs++; $display("FAIL annul_no_ready: got ready seen=1 want 0"); end
    do_div(32'd9, 32'd3, 1'b0, 1'b0, lat, res);
    exp = exp_q.pop_front();
    vecs++; if (lat != 34 || res !== exp) begin
      errs++; $display("FAIL annul_fresh: got lat=%0d res=%h want 34/%h", lat, res, exp);
    end
    // start with annul in IDLE must not launch; dropping annul launches next edge.
    start = 1'b1; annul = 1'b1; opdata1 = 32'd9; opdata2 = 32'd3;
    repeat (3) @(posedge clk);
    #1 annul = 1'b0;
    do_div(32'd9, 32'd3, 1'b0, 1'b0, lat, res);
    exp = exp_q.pop_front();
    vecs++; if (lat != 34 || res !== exp) begin
      errs++; $display("FAIL start_annul_idle: got lat=%0d res=%h want 34/%h", lat, res, exp);
    end
    // Annul on the final (sign fix) edge wins.
    start = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
    repeat (33) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1;
    vecs++; if (ready !== 1'b0 || result !== 64'd0) begin
      errs++; $display("FAIL annul_last_edge: got ready=%b result=%h want 0/0", ready, result);
    end
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
    // Annul in END drops ready.
    start = 1'b1; opdata1 = 32'd8; opdata2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL end_reached: got %b want 1", ready); end
    annul = 1'b1;
    @(posedge clk); #1;
    vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL annul_in_end: got %b want 0", ready); end
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [63:0] res, exp;
    do_div(32'd123456, 32'd789, 1'b0, 1'b1, lat, res);
    exp = exp_q.pop_front();
    vecs++; if (lat != 34 || res !== exp) begin
      errs++; $display("FAIL b2b_first: got lat=%0d res=%h want 34/%h", lat, res, exp);
    end
    do_div(32'hFFFF_0000, 32'd3, 1'b1, 1'b0, lat, res);
    exp = exp_q.pop_front();
    vecs++; if (lat != 34 || res !== exp) begin
      errs++; $display("FAIL b2b_second: got lat=%0d res=%h want 34/%h", lat, res, exp);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [63:0] exp;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vecs++; if (ready !== 1'b0 || result !== 64'd0) begin
      errs++; $display("FAIL rst_mid_out: got ready=%b result=%h want 0/0", ready, result);
    end
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL rst_mid_stall: got %b want 1", stall_req); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(model(32'd100, 32'd7, 1'b0));
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (ready) begin lat = n; break; end
    end
    exp = exp_q.pop_front();
    vecs++; if (lat != 34 || result !== exp) begin
      errs++; $display("FAIL rst_restart: got lat=%0d res=%h want 34/%h", lat, result, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] a, b;
    logic s;
    logic [63:0] res, exp;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      s = 1'($urandom_range(0, 1));
      do_div(a, b, s, 1'b0, lat, res);
      exp = exp_q.pop_front();
      vecs++; if (lat != ((b == 32'd0) ? 2 : 34) || res !== exp) begin
        errs++; $display("FAIL rand[%0d] %h/%h s=%b: got lat=%0d res=%h want %h", i, a, b, s, lat, res, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_signed;
    test_divzero;
    test_annul;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Iterative multi-cycle divider controller for DIV/DIVU in the EX stage. It accepts a request when the decoded funct selects a divide, then sequences a radix-2 restoring shift/subtract datapath for 32 iterations. While the divide is in flight it holds the pipeline with a stall request, and it hands the {remainder, quotient} pair to the HI/LO write path. It also honours pipeline flushes (`annul`) at any point in the operation.

## Interface
- `DATA_W`, 32, operand width; quotient and remainder are each `DATA_W` bits.
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  divide request from EX; held high until `ready` is seen.
- `signed_div`  input  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1`  input  DATA_W  dividend (rs).
- `opdata2`  input  DATA_W  divisor (rt).
- `annul`  input  1  flush: abort the current or pending divide.
- `result`  output  2*DATA_W  {remainder, quotient}; valid while `ready` = 1.
- `ready`  output  1  result valid.
- `stall_req`  output  1  pipeline hold request to the stall controller.

## Operation
- FSM states are IDLE, DIVZERO, ON and END.
- **IDLE**
  - `start` & ~`annul` & `opdata2` == 0 → DIVZERO.
  - `start` & ~`annul` & `opdata2` != 0 → ON.
  - On entering ON: latch the absolute values of both operands if `signed_div`, else the raw values; latch both operand signs and `signed_div`; clear `cnt` and the 65-bit working register, then load the dividend into its low half.
- **ON**, `cnt` < 32: one iteration per cycle.
  - Shift the working register left by 1.
  - Compute the trial difference `upper − divisor` (33-bit).
  - If it is non-negative, write it back to the upper half and set quotient bit 0 to 1; otherwise set bit 0 to 0.
  - Increment `cnt`.
- **ON**, `cnt` == 32: sign fix, then → END.
  - Quotient is negated if `signed_div` and the operand signs differ.
  - Remainder is negated if `signed_div` and the dividend is negative.
- **DIVZERO**: load result = 0, then → END. Divide-by-zero is defined to return {0, 0}.
- **END**: `ready` = 1 and `result` is held. When `start` = 0: → IDLE, `ready` ← 0, `result` ← 0.
- **Annul**: `annul` = 1 in ON or DIVZERO → IDLE next edge, `ready` stays 0, `result` ← 0. In END, `annul` → IDLE with `ready` ← 0.
- **Operand stability**: the operands are sampled only on the IDLE→ON edge. Changes afterwards are ignored.
- **Overflow**: signed −2^31 / −1 wraps to quotient 0x8000_0000, remainder 0. No trap is raised.
- **stall_req** is combinational: `start` & ~`annul` & (state != END). It is low in END so the pipeline advances on the same cycle `ready` is seen.

## Timing
- **Reset values** (asynchronous, on `rst` low): state IDLE, `cnt` 0, `ready` 0, `result` 0, working register 0. `stall_req` follows its equation, so it is 1 if `start` is high during reset.
- **Normal latency**: `start` sampled at edge E0; ON occupies E1..E33 (32 iterations plus the sign fix); END is entered at E34. `ready` = 1 from E34.
- **Divide-by-zero latency**: DIVZERO at E1, END at E2, so `ready` = 1 from E2.
- **Back-to-back requests**: the END→IDLE edge needs one cycle with `start` = 0. A new `start` is accepted on the following edge.
- **Simultaneous events**
  - `start` & `annul` in IDLE: no transition.
  - `annul` on the final iteration edge: abort wins and END is not entered.
- **Reset mid-operation**: immediate return to IDLE with all outputs cleared. No partial result leaks out.

## Structure
- Shared define file `div_def.v` (in the define directory):
  - state encodings `DIV_IDLE`, `DIV_ZERO`, `DIV_ON`, `DIV_END`;
  - `DIV_ITER` = 32;
  - `DIV_RESULT_BUS` = 63:0.
- Optional sub-module `div_step`: combinational trial subtract plus quotient-bit select. The FSM, counter, sign handling and output registers stay in `div_ctrl`.
- The EX-stage top decodes the `FUNCT_DIV` / `FUNCT_DIVU` codes into `start` and `signed_div`.

## Test plan
- DIVU 100 / 7 → `ready` at E34, `result` = {0x2, 0xE}; `stall_req` high E0..E33, low at E34.
- DIV −7 / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. DIV 7 / −2 → quotient 0xFFFF_FFFD, remainder 0x1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0. DIVU 0xFFFF_FFFF / 1 → quotient 0xFFFF_FFFF, remainder 0.
- Divide by zero (DIVU 5 / 0) → `ready` at E2, `result` = 0.
- `annul` asserted at E10 → IDLE at E11, `ready` never asserts, `result` = 0. A fresh DIVU 9 / 3 started afterwards gives quotient 3, remainder 0.
- `rst` low at E20 mid-divide → all outputs 0 immediately. `start` held through the release of `rst` → the divide restarts from the first edge after release.
